ray_dispatcher: RTL and testbench
=================================

// Module: ray_dispatcher
// PURPOSE
//  Front end of single_shader: scans the frame in raster order and drives one primary ray per pixel into the shader.
//  Drives the ray origin on init and the per-pixel direction on dir; single_shader is fed t/normal/normal_mold elsewhere.
//  Captures the returned 12-bit color after the shader's fixed latency and streams {addr,color} to the VRAM writer.
//  Credit-based flow control absorbs VRAM backpressure, because the shader pipeline itself cannot stall.
// PARAMETERS
//  H_RES        640   pixels per row
//  V_RES        480   rows per frame
//  FOCAL        256   z component of every ray dir, 9-bit unsigned
//  SHADER_LAT   8     cycles from ray_valid/ray_* presented to matching shade_color valid
//  FIFO_DEPTH   16    result FIFO entries, power of 2; >= SHADER_LAT+1 for full rate
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  start        in   1   pulse: begin a frame (ignored while busy)
//  cam_pos      in   28  camera origin {x[9:0],y[9:0],z[7:0]}, latched on accepted start
//  ray_init     out  28  ray origin to shader init
//  ray_dir      out  31  {dx s11, dy s11, dz u9} to shader dir
//  ray_valid    out  1   ray_* carries a new pixel this cycle
//  shade_color  in   12  shader color output {r4,g4,b4}
//  pix_addr     out  19  linear pixel address row*H_RES+col
//  pix_data     out  12  color for pix_addr
//  pix_valid    out  1   pix_* valid; held stable until pix_ready
//  pix_ready    in   1   VRAM writer accepts when pix_valid&pix_ready
//  busy         out  1   high from accepted start until frame_done
//  frame_done   out  1   one-cycle pulse after the last pixel is accepted
//  stall_cnt    out  32  issue-stall cycle count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters, delay line and FIFO cleared.
//  FSM: IDLE -start-> ISSUE; ISSUE -last ray issued-> DRAIN; DRAIN -FIFO empty & nothing in flight-> DONE; DONE -> IDLE (1 cycle).
//  frame_done=1 only in DONE. busy=1 in ISSUE/DRAIN/DONE.
//  Issue in ISSUE when credits>0: ray_valid=1 and ray_* registered. Otherwise ray_valid=0 and ray_* hold.
//  credits = FIFO_DEPTH - (rays in flight + FIFO occupancy).
//  Ray fields: dx = col - H_RES/2, dy = V_RES/2 - row, both 11-bit two's complement; dz = FOCAL.
//  ray_init = latched cam_pos.
//  col/row/addr counters: col wraps at H_RES-1 with row+1; addr increments by 1 per issue, no multiply.
//  Raster order: col 0..H_RES-1 within row, rows 0..V_RES-1.
//  Delay line: SHADER_LAT-stage shift register of {valid, addr}.
//  Delay line output: when its valid=1, push {addr, shade_color} into FIFO in that same cycle.
//  The push never overflows; the credit rule guarantees room.
//  FIFO output is registered: a pixel first appears on pix_valid SHADER_LAT+1 cycles after its ray_valid.
//  pix_addr strictly increasing within a frame; no drop, no duplicate.
//  pix_* held while pix_valid & ~pix_ready.
//  Simultaneous push and pop on the same cycle: both occur and occupancy is unchanged.
//  Pop of the last entry with no pending push: pix_valid=0 next cycle.
//  start during ISSUE/DRAIN/DONE: ignored, no re-latch of cam_pos.
//  start in the IDLE cycle directly following DONE: accepted normally.
//  rst mid-frame: abort at once, go IDLE, clear delay line.
//  After an abort, shader colors still arriving are not captured and no pix_valid follows.
// CONFIGURATION
//  RAY_DISPATCH_STATS_EN defined: stall_cnt clears on accepted start and on rst.
//  RAY_DISPATCH_STATS_EN defined: stall_cnt +1 each ISSUE cycle with credits=0, saturating at 2^32-1.
//  RAY_DISPATCH_STATS_EN undefined: stall_cnt tied to 0 and no counter logic.
// TESTING  (H_RES=4, V_RES=2, FOCAL=256, SHADER_LAT=3, FIFO_DEPTH=4, shader model = 3-cycle delay of color=addr)
//  rst=1 two cycles -> ray_valid, pix_valid, busy, frame_done, stall_cnt all 0.
//  start with pix_ready=1 -> 8 ray_valid on consecutive cycles; first dir={-2,+1,256}, last dir={+1,0,256}.
//  Same frame -> pix_addr 0..7 with pix_data=addr; first pix_valid 4 cycles after first ray_valid; frame_done pulses once.
//  pix_ready=0 from start -> exactly 4 rays issued then ray_valid=0; pix_addr=0 held.
//  Same stall, then pix_ready=1 -> remaining pixels delivered in order, 8 total; with RAY_DISPATCH_STATS_EN stall_cnt>0.
//  start asserted again at 3rd ray -> no restart; still exactly 8 pixels and one frame_done.
//  rst after 5th ray -> next cycle busy=0, ray_valid=0; zero pix_valid for 10 cycles despite shader output.

Source files
------------

// File: rtl/ray_dispatcher.sv
// Raster-order primary ray issuer for single_shader with credit-protected result FIFO.
// Optional issue-stall statistics counter enabled by defining RAY_DISPATCH_STATS_EN.
module ray_dispatcher #(
   parameter int unsigned H_RES      = 640,
   parameter int unsigned V_RES      = 480,
   parameter int unsigned FOCAL      = 256,
   parameter int unsigned SHADER_LAT = 8,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [27:0] cam_pos,
   output logic [27:0] ray_init,
   output logic [30:0] ray_dir,
   output logic        ray_valid,
   input  logic [11:0] shade_color,
   output logic [18:0] pix_addr,
   output logic [11:0] pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        busy,
   output logic        frame_done,
   output logic [31:0] stall_cnt
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1) + 1;
   localparam logic [18:0] LastAddr = 19'(H_RES * V_RES - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e state_q, state_d;

   logic [10:0] col_q, row_q, col_nx, row_nx;
   logic [18:0] addr_q;
   logic [27:0] ray_init_q;
   logic [30:0] ray_dir_q;

   logic [SHADER_LAT-1:0] dl_valid_q;
   logic [18:0]           dl_addr_q [SHADER_LAT];

   logic [30:0]     mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, in_flight_q, used;

   logic start_acc, push, pop, credit_ok;

   function automatic logic [30:0] dir_of(input logic [10:0] col, input logic [10:0] row);
      return {col - 11'(H_RES / 2), 11'(V_RES / 2) - row, 9'(FOCAL)};
   endfunction

   assign start_acc = (state_q == StIdle) && start;
   assign push      = dl_valid_q[SHADER_LAT-1];
   assign pix_valid = (count_q != '0);
   assign pop       = pix_valid && pix_ready;
   // A slot freed by this cycle's pop can be reused by this cycle's issue.
   assign used      = in_flight_q + count_q - CntW'(pop);
   assign credit_ok = (used < CntW'(FIFO_DEPTH));

   assign ray_init = ray_init_q;
   assign ray_dir  = ray_dir_q;
   assign pix_addr = mem_q[rd_ptr_q][30:12];
   assign pix_data = mem_q[rd_ptr_q][11:0];

   always_comb begin
      col_nx = col_q + 11'd1;
      row_nx = row_q;
      if (col_q == 11'(H_RES - 1)) begin
         col_nx = '0;
         row_nx = row_q + 11'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StIssue;
         StIssue: if (ray_valid && (addr_q == LastAddr)) state_d = StDrain;
         StDrain: if ((count_q == '0) && (in_flight_q == '0)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ray_* already hold the pending pixel; ray_valid qualifies them in the same cycle.
   always_comb begin
      ray_valid  = (state_q == StIssue) && credit_ok;
      busy       = (state_q != StIdle);
      frame_done = (state_q == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         addr_q      <= '0;
         ray_init_q  <= '0;
         ray_dir_q   <= '0;
         dl_valid_q  <= '0;
         in_flight_q <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         for (int unsigned i = 0; i < SHADER_LAT; i++) dl_addr_q[i] <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (start_acc) begin
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            ray_init_q <= cam_pos;
            ray_dir_q  <= dir_of(11'd0, 11'd0);
         end else if (ray_valid) begin
            col_q     <= col_nx;
            row_q     <= row_nx;
            addr_q    <= addr_q + 19'd1;
            ray_dir_q <= dir_of(col_nx, row_nx);
         end

         dl_valid_q[0] <= ray_valid;
         dl_addr_q[0]  <= addr_q;
         for (int unsigned i = 1; i < SHADER_LAT; i++) begin
            dl_valid_q[i] <= dl_valid_q[i-1];
            dl_addr_q[i]  <= dl_addr_q[i-1];
         end
         in_flight_q <= in_flight_q + CntW'(ray_valid) - CntW'(push);

         if (push) begin
            mem_q[wr_ptr_q] <= {dl_addr_q[SHADER_LAT-1], shade_color};
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_q + CntW'(push) - CntW'(pop);
      end
   end

`ifdef RAY_DISPATCH_STATS_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         stall_q <= '0;
      end else if ((state_q == StIssue) && !credit_ok && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher: dir table, pixel scoreboard, credit model,
// stall/restart/abort sequences and randomized VRAM backpressure.
module tb_ray_dispatcher;

   localparam int H     = 4;
   localparam int V     = 2;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;
   localparam int NPIX  = H * V;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        pix_ready = 1'b0;
   logic [27:0] cam_pos = '0;
   logic [27:0] ray_init;
   logic [30:0] ray_dir;
   logic        ray_valid;
   logic [11:0] shade_color;
   logic [18:0] pix_addr;
   logic [11:0] pix_data;
   logic        pix_valid;
   logic        busy;
   logic        frame_done;
   logic [31:0] stall_cnt;

   always #5 clk = ~clk;

   ray_dispatcher #(
      .H_RES     (H),
      .V_RES     (V),
      .FOCAL     (256),
      .SHADER_LAT(LAT),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cam_pos    (cam_pos),
      .ray_init   (ray_init),
      .ray_dir    (ray_dir),
      .ray_valid  (ray_valid),
      .shade_color(shade_color),
      .pix_addr   (pix_addr),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .busy       (busy),
      .frame_done (frame_done),
      .stall_cnt  (stall_cnt)
   );

   // Shader stand-in: color is the pixel address recovered from the ray direction.
   logic [11:0] sh_q [LAT];

   function automatic logic [11:0] dir2addr(input logic [30:0] d);
      int dx, dy;
      dx = int'($signed(d[30:20]));
      dy = int'($signed(d[19:9]));
      return 12'((V / 2 - dy) * H + (dx + H / 2));
   endfunction

   always @(posedge clk) begin
      sh_q[0] <= ray_valid ? dir2addr(ray_dir) : 12'h0;
      for (int i = 1; i < LAT; i++) sh_q[i] <= sh_q[i-1];
   end
   assign shade_color = sh_q[LAT-1];

   typedef struct {
      int          idx;
      logic [10:0] dx;
      logic [10:0] dy;
      logic [8:0]  dz;
   } dir_vec_t;

   dir_vec_t tbl [NPIX];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int rays_seen, pix_seen, done_cnt, first_ray, last_ray, first_pv, pv_cycles;
   bit issuing, hold_pending;
   logic [18:0] held_addr;
   logic [11:0] held_data;
   logic [30:0] dirs [NPIX];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic new_frame();
      rays_seen    = 0;
      pix_seen     = 0;
      done_cnt     = 0;
      first_ray    = -1;
      last_ray     = -1;
      first_pv     = -1;
      hold_pending = 1'b0;
      for (int k = 0; k < NPIX; k++) dirs[k] = '0;
   endtask

   // Reference model: issued-but-unaccepted pixels may never exceed the FIFO depth,
   // and while issuing a ray must go out whenever that bound allows it.
   task automatic monitor();
      if (pix_valid) pv_cycles++;
      if (pix_valid && first_pv < 0) first_pv = cyc;
      if (hold_pending) begin
         check("pix_hold_valid", 64'(pix_valid), 64'(1));
         check("pix_hold_addr", 64'(pix_addr), 64'(held_addr));
         check("pix_hold_data", 64'(pix_data), 64'(held_data));
      end
      hold_pending = pix_valid && !pix_ready;
      held_addr    = pix_addr;
      held_data    = pix_data;
      if (pix_valid && pix_ready) begin
         check("pix_addr_order", 64'(pix_addr), 64'(pix_seen));
         check("pix_data", 64'(pix_data), 64'(pix_seen));
         pix_seen++;
      end
      if (issuing) check("ray_valid_credit", 64'(ray_valid), 64'((rays_seen - pix_seen) < DEPTH));
      if (ray_valid) begin
         if (rays_seen < NPIX) dirs[rays_seen] = ray_dir;
         if (first_ray < 0) first_ray = cyc;
         last_ray = cyc;
         rays_seen++;
         if (rays_seen == NPIX) issuing = 1'b0;
      end
      if (frame_done) done_cnt++;
   endtask

   task automatic cycle(input logic st, input logic rdy, input logic r);
      @(posedge clk);
      #1;
      start     = st;
      pix_ready = rdy;
      rst       = r;
      @(negedge clk);
      cyc++;
      monitor();
   endtask

   // mode 0: always ready, 1: not ready for stall_len cycles then ready, 2: random ready
   task automatic run_frame(input int mode, input int restart_at, input int stall_len);
      logic        st, rdy;
      logic [27:0] cam;
      new_frame();
      cam     = 28'($urandom);
      cam_pos = cam;
      cycle(1'b1, mode == 0, 1'b0);
      issuing = 1'b1;
      for (int i = 1; i < 400 && done_cnt == 0; i++) begin
         if (mode == 1 && i == stall_len + 1) begin
            check("stall_rays_issued", 64'(rays_seen), 64'(DEPTH));
            check("stall_ray_valid", 64'(ray_valid), 64'(0));
            check("stall_pix_valid", 64'(pix_valid), 64'(1));
            check("stall_pix_addr", 64'(pix_addr), 64'(0));
         end
         st = (restart_at >= 0) && (rays_seen == restart_at);
         if (st) cam_pos = ~cam;
         if (mode == 0)      rdy = 1'b1;
         else if (mode == 1) rdy = (i > stall_len);
         else                rdy = ($urandom_range(0, 3) != 0);
         cycle(st, rdy, 1'b0);
         if (i == 1) check("busy_in_frame", 64'(busy), 64'(1));
      end
      check("frame_done_seen", 64'(done_cnt), 64'(1));
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
      check("frame_done_once", 64'(done_cnt), 64'(1));
      check("rays_per_frame", 64'(rays_seen), 64'(NPIX));
      check("pixels_per_frame", 64'(pix_seen), 64'(NPIX));
      check("busy_after_frame", 64'(busy), 64'(0));
      check("ray_init_latched", 64'(ray_init), 64'(cam));
      check("first_pix_latency", 64'(first_pv - first_ray), 64'(LAT + 1));
      if (mode == 0) check("rays_back_to_back", 64'(last_ray - first_ray), 64'(NPIX - 1));
      for (int k = 0; k < NPIX; k++)
         check($sformatf("ray_dir[%0d]", tbl[k].idx), 64'(dirs[k]),
               64'({tbl[k].dx, tbl[k].dy, tbl[k].dz}));
   endtask

   initial begin
      tbl[0] = '{0, -11'sd2, 11'sd1, 9'd256};
      tbl[1] = '{1, -11'sd1, 11'sd1, 9'd256};
      tbl[2] = '{2,  11'sd0, 11'sd1, 9'd256};
      tbl[3] = '{3,  11'sd1, 11'sd1, 9'd256};
      tbl[4] = '{4, -11'sd2, 11'sd0, 9'd256};
      tbl[5] = '{5, -11'sd1, 11'sd0, 9'd256};
      tbl[6] = '{6,  11'sd0, 11'sd0, 9'd256};
      tbl[7] = '{7,  11'sd1, 11'sd0, 9'd256};
      issuing   = 1'b0;
      pv_cycles = 0;
      new_frame();

      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      check("rst_ray_valid", 64'(ray_valid), 64'(0));
      check("rst_pix_valid", 64'(pix_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_frame_done", 64'(frame_done), 64'(0));
      check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
      cycle(1'b0, 1'b1, 1'b0);

      run_frame(0, -1, 0);
      check("stall_cnt_full_rate", 64'(stall_cnt), 64'(0));

      run_frame(1, -1, 12);
`ifdef RAY_DISPATCH_STATS_EN
      check("stall_cnt_counted", 64'(stall_cnt != 0), 64'(1));
`else
      check("stall_cnt_tied", 64'(stall_cnt), 64'(0));
`endif

      run_frame(0, 2, 0);

      // Abort after the fifth ray; in-flight shader results must be dropped.
      new_frame();
      cam_pos = 28'($urandom);
      cycle(1'b1, 1'b1, 1'b0);
      issuing = 1'b1;
      for (int i = 0; i < 50 && rays_seen < 5; i++) cycle(1'b0, 1'b1, 1'b0);
      check("abort_rays_before_rst", 64'(rays_seen), 64'(5));
      issuing = 1'b0;
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b0);
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_ray_valid", 64'(ray_valid), 64'(0));
      pv_cycles = 0;
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0);
      check("abort_no_pix_valid", 64'(pv_cycles), 64'(0));
      check("abort_no_frame_done", 64'(done_cnt), 64'(0));

      run_frame(0, -1, 0);
      for (int f = 0; f < 3; f++) run_frame(2, (f == 1) ? 4 : -1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
